// File: rtl/fifo_read_ctrl_if.sv
// Handshake bundle between a FIFO read port, fifo_read_ctrl and its downstream consumer.
// rd_word_cnt exists only when FIFO_RD_CTRL_CNT_EN is defined.
interface fifo_read_ctrl_if #(
  parameter int DATA_WIDTH = 7
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
`ifdef FIFO_RD_CTRL_CNT_EN
  logic [15:0]           rd_word_cnt;
`endif

  // master: the read controller itself
  modport master (
    input  fifo_empty, fifo_rd_data, flush, out_ready,
    output fifo_rd_en, out_valid, out_data
`ifdef FIFO_RD_CTRL_CNT_EN
    , output rd_word_cnt
`endif
  );

  // slave: the FIFO plus downstream consumer surrounding the controller
  modport slave (
    output fifo_empty, fifo_rd_data, flush, out_ready,
    input  fifo_rd_en, out_valid, out_data
`ifdef FIFO_RD_CTRL_CNT_EN
    , input rd_word_cnt
`endif
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// FIFO read controller: pops a 1-cycle-latency FIFO into a 3-entry skid buffer, full throughput.
// Optional macro FIFO_RD_CTRL_CNT_EN adds a saturating 16-bit handshake counter (rd_word_cnt).
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 7
) (
  input  logic          rd_clk,
  input  logic          rd_rst_n,
  fifo_read_ctrl_if.master bus
);

  localparam logic [1:0] LAST_IDX = 2'd2;

  logic [DATA_WIDTH-1:0] r_mem [0:2];
  logic [1:0]            r_head;
  logic [1:0]            r_tail;
  logic [1:0]            r_cnt;
  logic                  r_inflight;

  logic [2:0]            w_occupancy;
  logic                  w_rd_en;
  logic                  w_capture;
  logic                  w_pop;
  logic [1:0]            w_cnt_next;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  // Buffered plus in-flight words must never exceed the three skid slots, so the
  // read decision depends only on registered state and never on out_ready.
  assign w_occupancy = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign w_rd_en     = rd_rst_n && !bus.fifo_empty && !bus.flush && (w_occupancy < 3'd3);
  assign w_capture   = r_inflight && !bus.flush;
  assign w_pop       = (r_cnt != 2'd0) && bus.out_ready;

  always_comb begin
    // NOTE: default assigned first so every path drives w_cnt_next and no latch is inferred.
    w_cnt_next = r_cnt;
    case ({w_capture, w_pop})
      2'b10:   w_cnt_next = r_cnt + 2'd1;
      2'b01:   w_cnt_next = r_cnt - 2'd1;
      default: w_cnt_next = r_cnt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_head     <= 2'd0;
      r_tail     <= 2'd0;
      r_cnt      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (bus.flush) begin
        r_head <= 2'd0;
        r_tail <= 2'd0;
        r_cnt  <= 2'd0;
      end else begin
        if (w_capture) r_tail <= ptr_inc(r_tail);
        if (w_pop)     r_head <= ptr_inc(r_head);
        r_cnt <= w_cnt_next;
      end
    end
  end

  // NOTE: storage is reset on purpose so out_data reads zero during reset; it is only three words.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < 3; i++) r_mem[i] <= '0;
    end else if (w_capture) begin
      r_mem[r_tail] <= bus.fifo_rd_data;
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_valid  = (r_cnt != 2'd0);
  assign bus.out_data   = r_mem[r_head];

`ifdef FIFO_RD_CTRL_CNT_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_word_cnt <= 16'd0;
    end else if (w_pop && (r_word_cnt != 16'hFFFF)) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign bus.rd_word_cnt = r_word_cnt;
`endif

  // A capture into a full buffer would mean the occupancy gate on fifo_rd_en is broken.
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(w_capture && (r_cnt == 2'd3)));

  a_ptr_range: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    (r_head != 2'd3) && (r_tail != 2'd3) && (r_cnt != 2'd3 || r_head == r_tail));

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: queue-based reference model, directed and random traffic.
// Define FIFO_RD_CTRL_CNT_EN for both RTL and bench to exercise the rd_word_cnt counter.
module tb_fifo_read_ctrl;

  localparam int DW = 7;

  logic rd_clk = 1'b0;
  logic rd_rst_n;

  fifo_read_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_read_ctrl #(.DATA_WIDTH(DW)) dut (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .bus      (bus)
  );

  always #5 rd_clk = ~rd_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Environment: words still held by the emulated FIFO
  logic [DW-1:0] src_q[$];
  logic          hold_empty = 1'b0;
  logic          last_pop   = 1'b0;
  int            cyc        = 0;
  int            fall_cyc   = 0;

  // Reference model: words buffered, and whether a word is on its way from the FIFO
  logic [DW-1:0] m_q[$];
  logic          m_infl = 1'b0;
  logic [15:0]   m_cnt  = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_rd_en();
    return rd_rst_n && !bus.fifo_empty && !bus.flush && ((m_q.size() + int'(m_infl)) < 3);
  endfunction

  function automatic logic model_idle();
    return (src_q.size() == 0) && (m_q.size() == 0) && !m_infl;
  endfunction

  task automatic apply();
    bus.fifo_empty = (src_q.size() == 0) || hold_empty;
  endtask

  // One clock: advance the model from pre-edge inputs, then act as the FIFO after the edge.
  task automatic step();
    logic rd;
    logic pop;
    @(posedge rd_clk);
    cyc++;
    last_pop = bus.fifo_rd_en;
    if (rd_rst_n) begin
      rd  = exp_rd_en();
      pop = (m_q.size() != 0) && bus.out_ready;
      if (pop && (m_cnt != 16'hFFFF)) m_cnt++;
      if (bus.flush) begin
        m_q.delete();
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(bus.fifo_rd_data);
      end
      m_infl = rd;
    end
    #1;
    if (last_pop && (src_q.size() != 0)) bus.fifo_rd_data = src_q.pop_front();
    else                                 bus.fifo_rd_data = DW'($urandom);
    apply();
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) src_q.push_back(DW'(base + i));
    apply();
    fall_cyc = cyc;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    hold_empty    = 1'b0;
    apply();
    while (!model_idle() && (k < budget)) begin
      step();
      k++;
    end
    check("drained", {31'd0, model_idle()}, 32'd1);
  endtask

  task automatic collect(input int n, input int base, input string name);
    int got = 0;
    int k   = 0;
    while ((got < n) && (k < n * 4 + 10)) begin
      if (bus.out_valid && bus.out_ready) begin
        check(name, bus.out_data, base + got);
        got++;
      end
      step();
      k++;
    end
    check({name, "_count"}, got, n);
  endtask

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge rd_clk);
    check("rd_en", {31'd0, bus.fifo_rd_en}, {31'd0, exp_rd_en()});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, rd_rst_n && (m_q.size() != 0)});
    if (!rd_rst_n)            check("out_data_rst", bus.out_data, 32'd0);
    else if (m_q.size() != 0) check("out_data", bus.out_data, m_q[0]);
`ifdef FIFO_RD_CTRL_CNT_EN
    check("rd_word_cnt", bus.rd_word_cnt, m_cnt);
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int k;
    int pops;

    // Reset state, with the FIFO claiming data so the read strobe gating is visible
    rd_rst_n         = 1'b1;
    bus.fifo_empty   = 1'b0;
    bus.fifo_rd_data = '0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;
    #1 rd_rst_n = 1'b0;
    #1;
    check("reset_valid", bus.out_valid, 0);
    check("reset_rd_en", bus.fifo_rd_en, 0);
    check("reset_data", bus.out_data, 0);
    apply();
    step();
    step();
    rd_rst_n = 1'b1;
    step();

    // Streaming 0x01..0x10 with out_ready held high
    bus.out_ready = 1'b1;
    load(16, 1);
    got = 0;
    k   = 0;
    while ((got < 16) && (k < 40)) begin
      step();
      k++;
      if (bus.out_valid) begin
        if (got == 0) check("first_latency", cyc - fall_cyc, 2);
        check("stream_data", bus.out_data, got + 1);
        check("stream_cycle", cyc - fall_cyc, got + 2);
        got++;
      end
    end
    check("stream_count", got, 16);
    step();
    check("stream_end_valid", bus.out_valid, 0);
    drain(20);

    // Backpressure: 8 words, out_ready low for 5 cycles
    bus.out_ready = 1'b0;
    load(8, 'h20);
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (last_pop) pops++;
      if (bus.out_valid) check("bp_frozen", bus.out_data, 'h20);
    end
    check("bp_pops", pops, 3);
    check("bp_rd_en_low", bus.fifo_rd_en, 0);
    check("bp_valid", bus.out_valid, 1);
    check("bp_fifo_left", src_q.size(), 5);
    check("bp_model_cnt", m_q.size(), 3);
    bus.out_ready = 1'b1;
    collect(8, 'h20, "bp_order");
    drain(20);

    // Flush with two buffered words and one in flight
    bus.out_ready = 1'b0;
    load(8, 'h30);
    repeat (3) step();
    check("flush_setup_cnt", m_q.size(), 2);
    check("flush_setup_infl", m_infl, 1);
    bus.flush = 1'b1;
    #1;
    check("flush_rd_en", bus.fifo_rd_en, 0);
    step();
    check("flush_valid", bus.out_valid, 0);
    check("flush_model_empty", m_q.size(), 0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    collect(5, 'h33, "flush_next");
    drain(20);

    // Reset asserted mid-stream with two buffered words
    bus.out_ready = 1'b0;
    load(8, 'h40);
    repeat (3) step();
    check("rst_setup_cnt", m_q.size(), 2);
    #2;
    rd_rst_n = 1'b0;
    m_q.delete();
    m_infl = 1'b0;
    m_cnt  = 16'd0;
    #1;
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_rd_en", bus.fifo_rd_en, 0);
    check("rst_mid_data", bus.out_data, 0);
    src_q.delete();
    apply();
    step();
    step();
    rd_rst_n      = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_after_valid", bus.out_valid, 0);
    end

    // Random streams: random ready, FIFO gaps and occasional flushes
    for (int s = 0; s < 10; s++) begin
      int n = $urandom_range(24, 6);
      for (int i = 0; i < n; i++) src_q.push_back(DW'($urandom));
      apply();
      k = 0;
      while (!model_idle() && (k < 400)) begin
        bus.out_ready = ($urandom_range(3, 0) != 0);
        hold_empty    = ($urandom_range(4, 0) == 0);
        bus.flush     = ($urandom_range(49, 0) == 0);
        apply();
        step();
        k++;
      end
      drain(40);
      check("rand_end_valid", bus.out_valid, 0);
    end

`ifdef FIFO_RD_CTRL_CNT_EN
    // Counter saturation after 70000 handshakes since the last reset
    bus.out_ready = 1'b1;
    got = 0;
    k   = 0;
    while ((got < 70000) && (k < 72000)) begin
      if (src_q.size() < 4) for (int i = 0; i < 4; i++) src_q.push_back(DW'($urandom));
      apply();
      if (bus.out_valid && bus.out_ready) got++;
      step();
      k++;
    end
    check("cnt_handshakes", got, 70000);
    check("cnt_sat", bus.rd_word_cnt, 16'hFFFF);
    repeat (3) step();
    check("cnt_hold", bus.rd_word_cnt, 16'hFFFF);
    src_q.delete();
    drain(20);
`endif

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
